// File: rtl/fetch_buffer_pkg.sv
// Shared definitions for the instruction fetch buffer.
//   FB_DEPTH_DEFAULT : default number of queue entries
//   fb_state_t       : RUN / HOLD control state
//   FAULT_INSTR      : instruction word stored for a faulting fetch address
//   fb_entry_t       : one queue entry (pc, instr, fault), 65 bits
package fetch_buffer_pkg;

  localparam int unsigned FB_DEPTH_DEFAULT = 4;

  localparam logic [31:0] FAULT_INSTR = 32'h0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } fb_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fb_entry_t;

  localparam int unsigned ENTRY_W = $bits(fb_entry_t);

endpackage

// File: rtl/fetch_buffer_mem.sv
// Entry storage for the fetch buffer: DEPTH x 65 bits, one synchronous write
// port and one asynchronous read port.
//   clk, rst_n : clock; async active-low reset (clears the fault bits only)
//   wr_en      : write wr_data into entry wr_addr at the rising edge
//   wr_addr    : write index
//   wr_data    : packed fb_entry_t {pc, instr, fault}
//   rd_addr    : read index
//   rd_data    : packed fb_entry_t at rd_addr, combinational
module fetch_buffer_mem
  import fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = FB_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [ENTRY_W-1:0]       wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [ENTRY_W-1:0]       rd_data
);

  fb_entry_t   wr_entry;
  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];
  logic [DEPTH-1:0] fault_q;

  assign wr_entry = fb_entry_t'(wr_data);

  // Data words are not reset; only the fault flags are.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_addr]    <= wr_entry.pc;
      instr_mem[wr_addr] <= wr_entry.instr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= '0;
    end else if (wr_en) begin
      fault_q[wr_addr] <= wr_entry.fault;
    end
  end

  assign rd_data = {pc_mem[rd_addr], instr_mem[rd_addr], fault_q[rd_addr]};

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: circular queue between fetch and decode.
// A push with a faulting address stores a fault entry and parks the buffer
// in HOLD (no further pushes) until a flush redirects fetch.
//   clk, rst_n  : clock; async active-low reset
//   in_valid    : fetch offers {in_pc, in_instr, in_invalid}
//   in_ready    : buffer accepts the offer (PC enable)
//   out_valid   : head entry presented to decode
//   out_pc, out_instr, out_fault : head entry, zero when empty
//   out_ready   : decode consumes the head entry
//   flush       : discard all entries, return to RUN
//   level       : number of valid entries
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = FB_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [31:0]            in_pc,
  input  logic [31:0]            in_instr,
  input  logic                   in_invalid,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_instr,
  output logic                   out_fault,
  input  logic                   out_ready,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  fb_state_t       state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic            push, pop;
  fb_entry_t       wr_entry, rd_entry;
  logic [ENTRY_W-1:0] rd_data;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_RUN;
    end else if (state_q == ST_RUN && push && in_invalid) begin
      state_d = ST_HOLD;
    end
  end

  // Outputs of the state machine. in_ready is gated by rst_n so it reads 0
  // while reset is held, even though state and level already look idle.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n && state_q == ST_RUN && level_q < LW'(DEPTH)) begin
      in_ready = 1'b1;
    end
  end

  // Pointers and level; flush overrides any push/pop this cycle.
  // DEPTH is a power of two, so the pointers wrap naturally at DEPTH-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_comb begin
    wr_entry.pc    = in_pc;
    wr_entry.instr = in_invalid ? FAULT_INSTR : in_instr;
    wr_entry.fault = in_invalid;
  end

  fetch_buffer_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push & ~flush),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  assign rd_entry  = fb_entry_t'(rd_data);
  assign out_valid = (level_q != '0);
  assign out_pc    = out_valid ? rd_entry.pc    : '0;
  assign out_instr = out_valid ? rd_entry.instr : '0;
  assign out_fault = out_valid ? rd_entry.fault : 1'b0;
  assign level     = level_q;

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_invalid, out_ready, flush;
  logic [31:0] in_pc, in_instr;
  logic        in_ready, out_valid, out_fault;
  logic [31:0] out_pc, out_instr;
  logic [2:0]  level;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  fetch_buffer #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_pc      (in_pc),
    .in_instr   (in_instr),
    .in_invalid (in_invalid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .out_fault  (out_fault),
    .out_ready  (out_ready),
    .flush      (flush),
    .level      (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] ipc;
    logic [31:0] iins;
    logic        iinv;
    logic        ordy;
    logic        fl;
    int unsigned lvl;
    logic        irdy;
    logic        ov;
    logic [31:0] opc;
    logic [31:0] oins;
    logic        of;
  } vec_t;

  vec_t va[$];
  vec_t vb[$];

  function automatic vec_t mk(logic iv, logic [31:0] ipc, logic [31:0] iins,
                              logic iinv, logic ordy, logic fl, int unsigned lvl,
                              logic irdy, logic ov, logic [31:0] opc,
                              logic [31:0] oins, logic of);
    vec_t v;
    v.iv = iv; v.ipc = ipc; v.iins = iins; v.iinv = iinv; v.ordy = ordy;
    v.fl = fl; v.lvl = lvl; v.irdy = irdy; v.ov = ov; v.opc = opc;
    v.oins = oins; v.of = of;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int unsigned lvl, input logic irdy,
                          input logic ov, input logic [31:0] opc,
                          input logic [31:0] oins, input logic of);
    chk({tag, ".level"},     32'(level),     32'(lvl));
    chk({tag, ".in_ready"},  32'(in_ready),  32'(irdy));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".out_pc"},    out_pc,         opc);
    chk({tag, ".out_instr"}, out_instr,      oins);
    chk({tag, ".out_fault"}, 32'(out_fault), 32'(of));
  endtask

  task automatic drive(input logic iv, input logic [31:0] ipc, input logic [31:0] iins,
                       input logic iinv, input logic ordy, input logic fl);
    in_valid = iv; in_pc = ipc; in_instr = iins; in_invalid = iinv;
    out_ready = ordy; flush = fl;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after
  // the rising edge, so expected values describe the state after that edge.
  task automatic run_vec(input string tag, input vec_t v);
    @(negedge clk);
    drive(v.iv, v.ipc, v.iins, v.iinv, v.ordy, v.fl);
    @(posedge clk);
    #1;
    chk_outs(tag, v.lvl, v.irdy, v.ov, v.opc, v.oins, v.of);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] pc;
    logic [31:0] head;

    // Fill, full, full-with-pop, drain to level 2
    va.push_back(mk(1, 32'h3000, 32'hC0DE3000, 0, 0, 0, 1, 1, 1, 32'h3000, 32'hC0DE3000, 0));
    va.push_back(mk(1, 32'h3004, 32'hC0DE3004, 0, 0, 0, 2, 1, 1, 32'h3000, 32'hC0DE3000, 0));
    va.push_back(mk(1, 32'h3008, 32'hC0DE3008, 0, 0, 0, 3, 1, 1, 32'h3000, 32'hC0DE3000, 0));
    va.push_back(mk(1, 32'h300C, 32'hC0DE300C, 0, 0, 0, 4, 0, 1, 32'h3000, 32'hC0DE3000, 0));
    va.push_back(mk(1, 32'h3010, 32'hC0DE3010, 0, 0, 0, 4, 0, 1, 32'h3000, 32'hC0DE3000, 0));
    va.push_back(mk(1, 32'h3010, 32'hC0DE3010, 0, 1, 0, 3, 1, 1, 32'h3004, 32'hC0DE3004, 0));
    va.push_back(mk(0, 32'h0,    32'h0,        0, 1, 0, 2, 1, 1, 32'h3008, 32'hC0DE3008, 0));

    // Queue holds 3030, 3034 after the streaming loop
    vb.push_back(mk(1, 32'h2FFE, 32'hDEADBEEF, 1, 0, 0, 3, 0, 1, 32'h3030, 32'hC0DE3030, 0));
    vb.push_back(mk(1, 32'h3038, 32'hC0DE3038, 0, 0, 0, 3, 0, 1, 32'h3030, 32'hC0DE3030, 0));
    vb.push_back(mk(1, 32'h3038, 32'hC0DE3038, 0, 1, 0, 2, 0, 1, 32'h3034, 32'hC0DE3034, 0));
    vb.push_back(mk(1, 32'h3038, 32'hC0DE3038, 0, 1, 0, 1, 0, 1, 32'h2FFE, 32'h0,        1));
    vb.push_back(mk(1, 32'h3038, 32'hC0DE3038, 0, 0, 1, 0, 1, 0, 32'h0,    32'h0,        0));
    vb.push_back(mk(1, 32'h4000, 32'hC0DE4000, 0, 0, 0, 1, 1, 1, 32'h4000, 32'hC0DE4000, 0));
    vb.push_back(mk(1, 32'h4004, 32'hC0DE4004, 0, 0, 0, 2, 1, 1, 32'h4000, 32'hC0DE4000, 0));
    vb.push_back(mk(1, 32'h4008, 32'hC0DE4008, 0, 0, 0, 3, 1, 1, 32'h4000, 32'hC0DE4000, 0));
    vb.push_back(mk(1, 32'h400C, 32'hC0DE400C, 0, 1, 1, 0, 1, 0, 32'h0,    32'h0,        0));
    vb.push_back(mk(0, 32'h0,    32'h0,        0, 0, 0, 0, 1, 0, 32'h0,    32'h0,        0));
    vb.push_back(mk(1, 32'h4010, 32'hC0DE4010, 0, 0, 0, 1, 1, 1, 32'h4010, 32'hC0DE4010, 0));
    vb.push_back(mk(1, 32'h4014, 32'hC0DE4014, 0, 0, 0, 2, 1, 1, 32'h4010, 32'hC0DE4010, 0));
    vb.push_back(mk(1, 32'h4018, 32'hC0DE4018, 0, 0, 0, 3, 1, 1, 32'h4010, 32'hC0DE4010, 0));

    rst_n = 1'b0;
    drive(0, 32'h0, 32'h0, 0, 0, 0);
    #2;
    chk_outs("in_reset", 0, 0, 0, 32'h0, 32'h0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_outs("after_release", 0, 1, 0, 32'h0, 32'h0, 0);

    foreach (va[i]) run_vec($sformatf("va%0d", i), va[i]);

    // Streaming at level 2: push and pop every cycle across pointer wrap
    for (int k = 0; k < 10; k++) begin
      pc   = 32'h3010 + 32'(4 * k);
      head = 32'h300C + 32'(4 * k);
      @(negedge clk);
      drive(1, pc, {16'hC0DE, pc[15:0]}, 0, 1, 0);
      @(posedge clk);
      #1;
      chk_outs($sformatf("stream%0d", k), 2, 1, 1, head, {16'hC0DE, head[15:0]}, 0);
    end

    foreach (vb[i]) run_vec($sformatf("vb%0d", i), vb[i]);

    // Asynchronous reset mid-cycle at level 3
    @(negedge clk);
    drive(0, 32'h0, 32'h0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("async_reset", 0, 0, 0, 32'h0, 32'h0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_outs("reset_release", 0, 1, 0, 32'h0, 32'h0, 0);
    run_vec("post_reset_push",
            mk(1, 32'h5000, 32'hC0DE5000, 0, 0, 0, 1, 1, 1, 32'h5000, 32'hC0DE5000, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
